gsr_sequencer: RTL and testbench

Producer of the global set/reset net consumed by every GSR-enabled flip-flop primitive in the library. Synchronises and debounces an external active-low reset request, holds the active-low `GSRNET` asserted for a guaranteed minimum time, then releases it followed by a staged, spaced release of per-domain reset outputs. It also generates the power-up reset: `LSR` forces the net asserted and re-runs the full hold-and-release sequence.

---
 rtl/gsr_seq_pkg.sv | 23 ++
 rtl/gsr_req_sync.sv | 22 ++
 rtl/gsr_sequencer.sv | 153 +++++++++++++++
 tb/tb_gsr_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/gsr_seq_pkg.sv
// Shared types and helpers for the global set/reset sequencer.
package gsr_seq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILTER,
      ST_ASSERT,
      ST_WAIT_REL,
      ST_RELEASE
   } gsr_state_t;

   // Counter width large enough for the longest count any state needs,
   // so no counter ever wraps.
   function automatic int cnt_width(input int filter_cycles, input int hold_cycles,
                                    input int num_stages, input int stage_gap);
      int m;
      m = filter_cycles;
      if (hold_cycles > m) m = hold_cycles;
      if (num_stages * stage_gap > m) m = num_stages * stage_gap;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/gsr_req_sync.sv
// Flop-chain synchroniser for the asynchronous active-low reset request.
// Resets to 1 so a restart never sees a spurious request.
module gsr_req_sync #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // Shift the request through the chain; the last flop is the clean output.
   always_ff @(posedge clk) begin
      if (rst) ff <= '1;
      else     ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/gsr_sequencer.sv
// Global set/reset sequencer: filters a synchronised reset request, holds
// GSRNET low for a minimum time, then releases GSRNET followed by a spaced,
// in-order release of the per-domain resets. LSR restarts the whole sequence.
// All outputs are registered.
module gsr_sequencer
   import gsr_seq_pkg::*;
#(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 4,
   parameter int HOLD_CYCLES   = 16,
   parameter int NUM_STAGES    = 3,
   parameter int STAGE_GAP     = 2
) (
   input  logic                  CK,
   input  logic                  LSR,
   input  logic                  GSR_REQN,
   output logic                  GSRNET,
   output logic [NUM_STAGES-1:0] STAGE_RSTN,
   output logic                  BUSY,
   output logic                  DONE
);

   localparam int CW = cnt_width(FILTER_CYCLES, HOLD_CYCLES, NUM_STAGES, STAGE_GAP);
   localparam logic [CW-1:0] FILT_END = CW'(FILTER_CYCLES);
   localparam logic [CW-1:0] HOLD_END = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] REL_END  = CW'(NUM_STAGES * STAGE_GAP - 1);

   if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("gsr_sequencer: SYNC_STAGES must be >= 2");
   end
   if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("gsr_sequencer: FILTER_CYCLES must be >= 1");
   end
   if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("gsr_sequencer: HOLD_CYCLES must be >= 1");
   end
   if (NUM_STAGES < 1 || NUM_STAGES > 8) begin : g_bad_stages
      $error("gsr_sequencer: NUM_STAGES must be 1..8");
   end
   if (STAGE_GAP < 1) begin : g_bad_gap
      $error("gsr_sequencer: STAGE_GAP must be >= 1");
   end

   logic                  req_s;
   gsr_state_t            state, state_n;
   logic [CW-1:0]         cnt, cnt_n;
   logic                  gsr_n;
   logic [NUM_STAGES-1:0] stage_n;
   logic                  done_n;

   gsr_req_sync #(
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk (CK),
      .rst (LSR),
      .d   (GSR_REQN),
      .q   (req_s)
   );

   // State, counter and registered outputs; LSR overrides everything.
   always_ff @(posedge CK) begin
      if (LSR) begin
         state      <= ST_ASSERT;
         cnt        <= '0;
         GSRNET     <= 1'b0;
         STAGE_RSTN <= '0;
         BUSY       <= 1'b1;
         DONE       <= 1'b0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         GSRNET     <= gsr_n;
         STAGE_RSTN <= stage_n;
         BUSY       <= (state_n != ST_IDLE);
         DONE       <= done_n;
      end
   end

   // Next state, counter and next output values.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      gsr_n   = GSRNET;
      stage_n = STAGE_RSTN;
      done_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            gsr_n   = 1'b1;
            stage_n = '1;
            if (!req_s) begin
               state_n = ST_FILTER;
               cnt_n   = CW'(1);
            end
         end
         ST_FILTER: begin
            if (cnt == FILT_END) begin
               state_n = ST_ASSERT;
               cnt_n   = '0;
               gsr_n   = 1'b0;
               stage_n = '0;
            end else if (req_s) begin
               // glitch rejected, outputs untouched
               state_n = ST_IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_ASSERT: begin
            gsr_n   = 1'b0;
            stage_n = '0;
            if (cnt == HOLD_END) begin
               cnt_n = '0;
               if (req_s) begin
                  state_n = ST_RELEASE;
                  gsr_n   = 1'b1;
               end else begin
                  state_n = ST_WAIT_REL;
               end
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         ST_WAIT_REL: begin
            gsr_n   = 1'b0;
            stage_n = '0;
            if (req_s) begin
               state_n = ST_RELEASE;
               cnt_n   = '0;
               gsr_n   = 1'b1;
            end
         end
         ST_RELEASE: begin
            gsr_n = 1'b1;
            cnt_n = cnt + CW'(1);
            for (int i = 0; i < NUM_STAGES; i++) begin
               if (int'(cnt_n) >= (i + 1) * STAGE_GAP) stage_n[i] = 1'b1;
            end
            if (cnt == REL_END) begin
               state_n = ST_IDLE;
               cnt_n   = '0;
               stage_n = '1;
               done_n  = 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            cnt_n   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_gsr_sequencer.sv
// Self-checking bench for gsr_sequencer. Each scenario drives LSR/GSR_REQN
// cycle by cycle, pushes the expected registered outputs (derived from the
// timing rules) onto a queue, and pops/compares them after every edge.
module tb_gsr_sequencer;

   localparam int S   = 2;
   localparam int F   = 4;
   localparam int H   = 16;
   localparam int N   = 3;
   localparam int G   = 2;
   localparam int BIG = 1000000;

   logic         CK;
   logic         LSR;
   logic         GSR_REQN;
   logic         GSRNET;
   logic [N-1:0] STAGE_RSTN;
   logic         BUSY;
   logic         DONE;

   // {GSRNET, STAGE_RSTN[2:0], BUSY, DONE}
   logic [N+2:0] exp_q[$];
   int           n_checks;
   int           n_pass;

   gsr_sequencer #(
      .SYNC_STAGES   (S),
      .FILTER_CYCLES (F),
      .HOLD_CYCLES   (H),
      .NUM_STAGES    (N),
      .STAGE_GAP     (G)
   ) dut (
      .CK         (CK),
      .LSR        (LSR),
      .GSR_REQN   (GSR_REQN),
      .GSRNET     (GSRNET),
      .STAGE_RSTN (STAGE_RSTN),
      .BUSY       (BUSY),
      .DONE       (DONE)
   );

   // clock / reset defaults
   initial begin
      CK = 1'b0;
      forever #5 CK = ~CK;
   end

   task automatic check(input string tag, input logic [N+2:0] obs, input logic [N+2:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s got %b expected %b", tag, obs, exp);
   endtask

   // Expected outputs after edge k, given assert edge a, GSRNET release
   // edge r, and a FILTER-busy window [fs, fe).
   function automatic logic [N+2:0] exp_vec(input int k, input int a, input int r,
                                            input int fs, input int fe);
      logic         gsr, busy, done;
      logic [N-1:0] st;
      gsr = !(k >= a && k < r);
      for (int i = 0; i < N; i++) st[i] = !(k >= a && k < r + (i + 1) * G);
      busy = (k >= fs && k < fe) || (k >= a && k < r + N * G);
      done = (k == r + N * G);
      return {gsr, st, busy, done};
   endfunction

   // One scenario: GSR_REQN low for edges [0,n), an extra low pulse for
   // edges [pulse_at, pulse_at+2), LSR high for edges [lsr_s, lsr_e].
   task automatic run_scn(input string tag, input int n, input int pulse_at,
                          input int lsr_s, input int lsr_e, input int len);
      int a, r, fs, fe;
      logic [N+2:0] e;
      for (int k = 0; k < len; k++) begin
         LSR      = (lsr_s >= 0 && k >= lsr_s && k <= lsr_e);
         GSR_REQN = !((k < n) || (pulse_at >= 0 && k >= pulse_at && k < pulse_at + 2));
         if (lsr_s >= 0 && k >= lsr_s) begin
            a = lsr_s; r = lsr_e + H; fs = a; fe = a;
         end else if (n >= F) begin
            a = S + F;
            r = (n + S > a + H) ? n + S : a + H;
            fs = S; fe = a;
         end else if (n > 0) begin
            a = BIG; r = BIG; fs = S; fe = n + S;
         end else begin
            a = BIG; r = BIG; fs = 0; fe = 0;
         end
         exp_q.push_back(exp_vec(k, a, r, fs, fe));
         @(posedge CK);
         #1;
         e = exp_q.pop_front();
         check($sformatf("%s k=%0d", tag, k), {GSRNET, STAGE_RSTN, BUSY, DONE}, e);
      end
   endtask

   initial begin
      int n_rand;
      n_checks = 0;
      n_pass   = 0;
      LSR      = 1'b1;
      GSR_REQN = 1'b1;
      #1;
      run_scn("powerup",      0,  -1,  0,  2, 30);
      run_scn("glitch",       3,  -1, -1, -1, 15);
      run_scn("valid40",      40, -1, -1, -1, 55);
      run_scn("short6",       6,  -1, -1, -1, 35);
      run_scn("req_in_rel",   6,  23, -1, -1, 40);
      run_scn("lsr_mid_rel",  6,  -1, 25, 25, 55);
      run_scn("filter_min",   F,  -1, -1, -1, 35);
      for (int t = 0; t < 3; t++) begin
         n_rand = $urandom_range(1, 30);
         run_scn($sformatf("rand%0d_n%0d", t, n_rand), n_rand, -1, -1, -1, n_rand + S + H + 15);
      end
      n_checks++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL queue_drain got %0d expected 0", exp_q.size());
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
